// File: rtl/gpio_ahb_arb.sv
// Two-requester arbiter driving single AHB transfers (IDLE -> ADDR -> DATA).
// Define GPIO_AHB_ARB_RR_EN for round-robin arbitration; the default is fixed priority to requester 0.
module gpio_ahb_arb (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req0,
  input  logic        req1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rd,
  output logic [4:0]  haddr,
  output logic        hwrite,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]  state;
  logic        win;
  logic        grant;
  logic [31:0] lat_wd;
  logic        unused_hresp;

  // The slave response is not acted upon.
  assign unused_hresp = ^hresp;

`ifdef GPIO_AHB_ARB_RR_EN
  logic last;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = ~last;
    else              grant = ~req0;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                            last <= 1'b1;
    else if (state == IDLE && (req0 | req1)) last <= grant;
  end
`else
  always_comb begin
    grant = 1'b0;
    grant = ~req0;
  end
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state  <= IDLE;
      win    <= 1'b0;
      haddr  <= '0;
      hwrite <= 1'b0;
      lat_wd <= '0;
      hwdata <= '0;
      rd     <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state  <= ADDR;
            win    <= grant;
            haddr  <= grant ? addr1 : addr0;
            hwrite <= grant ? we1   : we0;
            lat_wd <= grant ? wd1   : wd0;
          end
        end
        ADDR: begin
          state  <= DATA;
          hwdata <= lat_wd;
        end
        DATA: begin
          if (hready) begin
            state <= IDLE;
            rd    <= hrdata;
            ack0  <= ~win;
            ack1  <= win;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hsel   = (state == ADDR);
  assign htrans = hsel ? 2'b10 : 2'b00;
  assign hsize  = 3'b010;
  assign hburst = 3'b000;

endmodule

// File: tb/tb_gpio_ahb_arb.sv
// Randomized bench for gpio_ahb_arb against a transaction-level model of pending requests and grants.
module tb_gpio_ahb_arb;
  logic        hclk = 1'b0;
  logic        hreset;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wd0, wd1;
  logic        ack0, ack1;
  logic [31:0] rd;
  logic [4:0]  haddr;
  logic        hwrite, hsel;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata, hrdata;
  logic        hready;
  logic [1:0]  hresp;

  gpio_ahb_arb dut (
    .hclk(hclk), .hreset(hreset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wd0(wd0), .wd1(wd1),
    .ack0(ack0), .ack1(ack1), .rd(rd),
    .haddr(haddr), .hwrite(hwrite), .hsel(hsel), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: each requester either has a pending transfer (with its payload) or not.
  bit          pend [2];
  logic [4:0]  p_addr [2];
  logic        p_we [2];
  logic [31:0] p_wd [2];
  bit          last_grant;
  int          last_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    req0 = pend[0]; addr0 = p_addr[0]; we0 = p_we[0]; wd0 = p_wd[0];
    req1 = pend[1]; addr1 = p_addr[1]; we1 = p_we[1]; wd1 = p_wd[1];
  endtask

  task automatic add_req(input int i);
    pend[i]   = 1'b1;
    p_addr[i] = 5'($urandom);
    p_we[i]   = 1'($urandom);
    p_wd[i]   = $urandom;
  endtask

  task automatic new_reqs();
    for (int i = 0; i < 2; i++)
      if (!pend[i] && $urandom_range(0, 1) == 1) add_req(i);
  endtask

  function automatic int pick_winner();
    if (pend[0] && pend[1]) begin
`ifdef GPIO_AHB_ARB_RR_EN
      return (last_grant == 1'b1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  // Starts at a negedge with the DUT in IDLE and at least one request pending; ends at the ack negedge.
  task automatic xfer(input int unsigned waits, input bit do_reset);
    int          w;
    logic [4:0]  ea;
    logic        ew;
    logic [31:0] ewd, erd;
    w   = pick_winner();
    ea  = p_addr[w]; ew = p_we[w]; ewd = p_wd[w];
    drive_reqs();
    hready = 1'($urandom);
    @(negedge hclk);
    check("addr_hsel", 32'(hsel), 32'd1);
    check("addr_htrans", 32'(htrans), 32'd2);
    check("addr_haddr", 32'(haddr), 32'(ea));
    check("addr_hwrite", 32'(hwrite), 32'(ew));
    check("hsize", 32'(hsize), 32'd2);
    check("hburst", 32'(hburst), 32'd0);
    check("addr_ack", 32'({ack0, ack1}), 32'd0);
    // Winner changes its payload after the grant; the transfer must not notice.
    if (w == 0) begin addr0 = 5'($urandom); we0 = 1'($urandom); wd0 = $urandom; end
    else        begin addr1 = 5'($urandom); we1 = 1'($urandom); wd1 = $urandom; end
    hready = (waits == 0);
    hrdata = $urandom; erd = hrdata;
    @(negedge hclk);
    check("data_hsel", 32'(hsel), 32'd0);
    check("data_htrans", 32'(htrans), 32'd0);
    check("data_hwdata", hwdata, ewd);
    check("data_ack", 32'({ack0, ack1}), 32'd0);
    if (do_reset) begin
      hready = 1'b0;
      hreset = 1'b1;
      #1;
      check("rst_hsel", 32'(hsel), 32'd0);
      check("rst_htrans", 32'(htrans), 32'd0);
      check("rst_haddr", 32'(haddr), 32'd0);
      check("rst_hwrite", 32'(hwrite), 32'd0);
      check("rst_hwdata", hwdata, 32'd0);
      check("rst_rd", rd, 32'd0);
      check("rst_ack", 32'({ack0, ack1}), 32'd0);
      pend[0] = 1'b0; pend[1] = 1'b0;
      last_grant = 1'b1;
      drive_reqs();
      @(negedge hclk);
      hreset = 1'b0;
      @(negedge hclk);
      check("post_rst_hsel", 32'(hsel), 32'd0);
      check("post_rst_ack", 32'({ack0, ack1}), 32'd0);
      last_win = -1;
      return;
    end
    for (int k = 0; k < int'(waits); k++) begin
      @(negedge hclk);
      check("wait_hsel", 32'(hsel), 32'd0);
      check("wait_hwdata", hwdata, ewd);
      check("wait_ack", 32'({ack0, ack1}), 32'd0);
      hready = (k == int'(waits) - 1);
      hrdata = $urandom; erd = hrdata;
    end
    @(negedge hclk);
    check("ack0", 32'(ack0), 32'(w == 0));
    check("ack1", 32'(ack1), 32'(w == 1));
    check("rd", rd, erd);
    pend[w]    = 1'b0;
    last_grant = 1'(w);
    last_win   = w;
  endtask

  initial begin
    int exp_order [4];
    hreset = 1'b1;
    hready = 1'b1; hrdata = '0; hresp = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin p_addr[i] = '0; p_we[i] = 1'b0; p_wd[i] = '0; end
    last_grant = 1'b1;
    drive_reqs();
    @(negedge hclk);
    @(negedge hclk);
    check("reset_hsel", 32'(hsel), 32'd0);
    check("reset_htrans", 32'(htrans), 32'd0);
    check("reset_haddr", 32'(haddr), 32'd0);
    check("reset_hwdata", hwdata, 32'd0);
    check("reset_rd", rd, 32'd0);
    check("reset_ack", 32'({ack0, ack1}), 32'd0);
    hreset = 1'b0;
    @(negedge hclk);

    // Both requesters keep asking; the winner re-asserts right after each ack.
`ifdef GPIO_AHB_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    add_req(0); add_req(1);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0);
      check("grant_order", 32'(last_win), 32'(exp_order[i]));
      add_req(last_win);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_reqs();
    @(negedge hclk);
    check("idle_ack_drop", 32'({ack0, ack1}), 32'd0);

    for (int n = 0; n < 200; n++) begin
      new_reqs();
      if (!pend[0] && !pend[1]) begin
        drive_reqs();
        @(negedge hclk);
        check("idle_hsel", 32'(hsel), 32'd0);
        check("idle_ack", 32'({ack0, ack1}), 32'd0);
      end else begin
        xfer($urandom_range(0, 3), $urandom_range(0, 24) == 0);
      end
    end

    // Reset while waiting in DATA, then a plain request must complete.
    pend[1] = 1'b0;
    add_req(0);
    xfer(2, 1'b1);
    add_req(0);
    xfer(1, 1'b0);
    check("after_reset_win", 32'(last_win), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_ahb_arb.md
GPIO_AHB_ARB -- requirements
Module: gpio_ahb_arb

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the address width at 5 bits.
REQ-002 The block SHALL run on one clock with an asynchronous, active-high reset.
REQ-003 hclk  input  1  clock; all state updates on the rising edge.
REQ-004 hreset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  requester N transfer request; held until ackN.
REQ-006 addr0 / addr1  input  5 each  requester N register address.
REQ-007 we0 / we1  input  1 each  requester N write (1) or read (0).
REQ-008 wd0 / wd1  input  32 each  requester N write data.
REQ-009 ack0 / ack1  output  1 each  one-cycle completion pulse to requester N.
REQ-010 rd  output  32  read data; valid while ack0 or ack1 is high.
REQ-011 haddr  output  5  AHB address.
REQ-012 hwrite  output  1  AHB write.
REQ-013 hsel  output  1  AHB slave select.
REQ-014 htrans  output  2  AHB transfer type.
REQ-015 hsize  output  3  AHB transfer size; constant 3'b010.
REQ-016 hburst  output  3  AHB burst type; constant 3'b000.
REQ-017 hwdata  output  32  AHB write data.
REQ-018 hrdata  input  32  AHB read data.
REQ-019 hready  input  1  slave ready.
REQ-020 hresp  input  2  slave response; ignored.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, ADDR and DATA, and SHALL make these transitions:
- IDLE->ADDR when req0|req1.
- ADDR->DATA unconditionally.
- DATA->IDLE when hready=1.
- DATA holds while hready=0.
REQ-022 On the IDLE->ADDR edge the winner index and its addr/we/wd SHALL be latched into internal registers; later changes on the requester inputs SHALL have no effect on the transfer in flight.
REQ-023 In ADDR, all of the following SHALL hold:
- hsel=1 and htrans=2'b10.
- haddr and hwrite are taken from the latched values.
REQ-024 In IDLE and DATA, hsel=0 and htrans=2'b00.
REQ-025 hwdata SHALL equal the latched wd in DATA and SHALL hold its last value otherwise.
REQ-026 On the DATA->IDLE edge, the following SHALL happen:
- rd <= hrdata.
- ackN of the winner <= 1 for exactly one cycle.
- ack of the other requester stays 0.
REQ-027 Latency SHALL be fixed at 3 edges with hready=1: request sampled at edge E0, ack high during E2..E3; each extra wait cycle adds one cycle.
REQ-028 Throughput SHALL be at most one transfer per 3 cycles, since IDLE is always visited between transfers.
REQ-029 A requester SHALL drop req during its ack cycle; a req still high on the edge after ack SHALL be taken as a new request.
REQ-030 When req0 and req1 are high together, arbitration SHALL follow REQ-037/REQ-038; a single active request SHALL always be granted.
REQ-031 A request that arrives while the FSM is in ADDR or DATA SHALL wait and be arbitrated on the next IDLE edge.
REQ-032 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-033 While hreset=1, the block SHALL hold these values:
- state=IDLE.
- hsel=0, htrans=0.
- haddr=0, hwrite=0, hwdata=0.
- rd=0.
- ack0=ack1=0.
- last-grant pointer=1, so that requester 0 is favoured first.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no ack; the aborted transfer SHALL not be reissued after reset.

Configuration
REQ-035 The macro GPIO_AHB_ARB_RR_EN SHALL select the arbitration policy.
REQ-036 Only the arbitration logic SHALL differ between builds; all timing SHALL be identical with and without the macro.
REQ-037 With GPIO_AHB_ARB_RR_EN defined, arbitration SHALL be round-robin:
- On a tie, the requester not granted last wins.
- The pointer updates on every grant.
REQ-038 Without GPIO_AHB_ARB_RR_EN, arbitration SHALL be fixed priority: req0 always wins a tie, and no pointer is kept.

Verification
REQ-039 Single write: req0=1, addr0=5'h04, we0=1, wd0=32'hA5 with hready=1 -> ADDR cycle shows hsel=1, htrans=2'b10, haddr=4, hwrite=1; next cycle hwdata=32'hA5; ack0 pulses 1 cycle at E2.
REQ-040 Single read with wait states: req1=1, we1=0, addr1=5'h08, hready held 0 for 2 DATA cycles, then 1 with hrdata=32'h3C -> ack1 pulses at E4 with rd=32'h3C.
REQ-041 Simultaneous requests held through 4 transfers:
- Built with GPIO_AHB_ARB_RR_EN: grant order 0,1,0,1.
- Built without it: order 0,0,0,0 while req0 is re-asserted.
REQ-042 Input change after grant: wd0 changes from 32'h11 to 32'h22 during ADDR -> hwdata=32'h11 in DATA.
REQ-043 Reset during DATA: hreset pulsed with hready=0 -> hsel=0, no ack, state IDLE; a new req0 afterwards completes normally.
